sdram_frame_buffer_mgr: RTL and testbench
=========================================

SDRAM_FRAME_BUFFER_MGR -- requirements
Module: sdram_frame_buffer_mgr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, SDRAM word-address width.
REQ-002 SHALL have parameter NUM_BUFFERS, default 3, frame buffer count; legal range 2..4.
REQ-003 SHALL have parameter BUFFER_SIZE, default 307200, words per buffer.
REQ-004 SHALL have parameter BASE_ADDR, default 0, address of buffer 0.
REQ-005 SHALL have parameter DROP_CNT_WIDTH, default 16, drop counter width.
REQ-006 SHALL have port axi_clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port axi_rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port wr_frame_req  input  1  writer requests a buffer for a new frame (1-cycle pulse).
REQ-009 SHALL have port wr_frame_done  input  1  writer finished its held buffer (1-cycle pulse).
REQ-010 SHALL have port wr_frame_ack  output  1  grant pulse for wr_frame_req.
REQ-011 SHALL have port wr_base_addr  output  ADDR_WIDTH  base address of the writer's buffer.
REQ-012 SHALL have port wr_buf_idx  output  $clog2(NUM_BUFFERS)  writer's buffer index.
REQ-013 SHALL have port rd_frame_req  input  1  reader (VGA path) requests the next frame (1-cycle pulse).
REQ-014 SHALL have port rd_frame_ack  output  1  grant pulse for rd_frame_req.
REQ-015 SHALL have port rd_base_addr  output  ADDR_WIDTH  base address of the reader's buffer.
REQ-016 SHALL have port rd_buf_idx  output  $clog2(NUM_BUFFERS)  reader's buffer index.
REQ-017 SHALL have port rd_repeat  output  1  qualifies rd_frame_ack: no new frame, previous buffer reused.
REQ-018 SHALL have port rd_has_frame  output  1  reader holds a completed frame.
REQ-019 SHALL have port drop_count  output  DROP_CNT_WIDTH  completed frames discarded unread.

Function
REQ-020 Each buffer SHALL hold one state: FREE, WRITING, READY, READING; at most one WRITING, one READY, one READING.
REQ-021 Buffer i base address SHALL be BASE_ADDR + i*BUFFER_SIZE, computed at ADDR_WIDTH; elaboration SHALL fail if BASE_ADDR + NUM_BUFFERS*BUFFER_SIZE > 2^ADDR_WIDTH or NUM_BUFFERS outside 2..4.
REQ-022 Per cycle, events SHALL be resolved in order wr_frame_done, then rd_frame_req, then wr_frame_req, each seeing prior results; next state registered at cycle end.
REQ-023 wr_frame_done with a WRITING buffer: it becomes READY; any previously READY buffer becomes FREE and drop_count increments. wr_frame_done with no WRITING buffer: ignored.
REQ-024 rd_frame_req with a READY buffer: reader's held buffer (if any) becomes FREE, READY buffer becomes READING, rd_repeat=0, rd_has_frame=1.
REQ-025 rd_frame_req with no READY buffer: holdings unchanged, rd_repeat=1, rd_base_addr/rd_buf_idx unchanged.
REQ-026 wr_frame_req while a buffer is WRITING: ignored, no ack.
REQ-027 Otherwise wr_frame_req SHALL take the lowest-index FREE buffer; if none, the READY buffer is reclaimed as WRITING and drop_count increments.
REQ-028 The READY buffer being taken by a same-cycle rd_frame_req SHALL NOT be given to the writer; the writer gets the buffer the reader released.
REQ-029 wr_frame_ack/rd_frame_ack SHALL pulse exactly one cycle, the cycle after the accepted request; addr/idx/rd_repeat valid with ack and stable until the next ack.
REQ-030 drop_count SHALL saturate at all-ones; two increments in one cycle are impossible by REQ-020.
REQ-031 Requests asserted on consecutive cycles SHALL each be evaluated independently; no request is queued.

Reset
REQ-032 While axi_rst=1, all buffers FREE; acks, rd_repeat, rd_has_frame, drop_count, wr/rd_buf_idx = 0; wr/rd_base_addr = BASE_ADDR; inputs ignored.
REQ-033 Reset asserted mid-frame SHALL abandon all holdings without counting drops; first request after release behaves as from power-up.

Verification
REQ-034 Reset, rd_frame_req -> next cycle rd_frame_ack=1, rd_repeat=1, rd_has_frame=0, rd_base_addr=0.
REQ-035 N=3: wr_req -> ack, wr_base_addr=0; wr_done; rd_req -> rd_base_addr=0, rd_repeat=0; wr_req -> wr_base_addr=307200.
REQ-036 N=3: two frames completed with no rd_req -> drop_count=1; rd_req -> rd_base_addr of second frame's buffer.
REQ-037 N=2, reader holds buf1, buf0 READY: wr_req alone -> writer gets buf0, drop_count+1; wr_req with rd_req same cycle -> reader buf0, writer buf1, no drop.
REQ-038 wr_done and rd_req same cycle -> reader receives the just-completed buffer, rd_repeat=0; wr_done+wr_req same cycle -> new buffer granted.
REQ-039 Reset mid-frame with drop_count=5 -> drop_count=0, all buffers FREE, next wr_req gets base 0.

Source files
------------

// File: rtl/sdram_frame_buffer_mgr_if.sv
// sdram_frame_buffer_mgr_if: handshake bundle between the frame buffer manager and its writer/reader clients
// master: drives wr_frame_req, wr_frame_done, rd_frame_req; observes grants, addresses, indices, status
// slave:  the manager side, the mirror image of master
interface sdram_frame_buffer_mgr_if #(
    parameter int ADDR_WIDTH     = 24,
    parameter int NUM_BUFFERS    = 3,
    parameter int DROP_CNT_WIDTH = 16
);
    localparam int IW = $clog2(NUM_BUFFERS);
    logic                      wr_frame_req;
    logic                      wr_frame_done;
    logic                      wr_frame_ack;
    logic [ADDR_WIDTH-1:0]     wr_base_addr;
    logic [IW-1:0]             wr_buf_idx;
    logic                      rd_frame_req;
    logic                      rd_frame_ack;
    logic [ADDR_WIDTH-1:0]     rd_base_addr;
    logic [IW-1:0]             rd_buf_idx;
    logic                      rd_repeat;
    logic                      rd_has_frame;
    logic [DROP_CNT_WIDTH-1:0] drop_count;
    modport master (
        output wr_frame_req, wr_frame_done, rd_frame_req,
        input  wr_frame_ack, wr_base_addr, wr_buf_idx, rd_frame_ack, rd_base_addr, rd_buf_idx,
               rd_repeat, rd_has_frame, drop_count
    );
    modport slave (
        input  wr_frame_req, wr_frame_done, rd_frame_req,
        output wr_frame_ack, wr_base_addr, wr_buf_idx, rd_frame_ack, rd_base_addr, rd_buf_idx,
               rd_repeat, rd_has_frame, drop_count
    );
endinterface

// File: rtl/sdram_frame_buffer_mgr.sv
// sdram_frame_buffer_mgr: rotates NUM_BUFFERS SDRAM frame buffers between one writer and one reader
// axi_clk: single clock; axi_rst: synchronous active-high reset
// bus (slave): writer req/done -> ack, base address, index; reader req -> ack, base address, index,
//              repeat flag, has-frame flag; saturating count of completed frames dropped unread
module sdram_frame_buffer_mgr #(
    parameter int ADDR_WIDTH     = 24,
    parameter int NUM_BUFFERS    = 3,
    parameter int BUFFER_SIZE    = 307200,
    parameter int BASE_ADDR      = 0,
    parameter int DROP_CNT_WIDTH = 16
) (
    input logic                     axi_clk,
    input logic                     axi_rst,
    sdram_frame_buffer_mgr_if.slave bus
);
    localparam int IW = $clog2(NUM_BUFFERS);
    localparam longint END_ADDR = longint'(BASE_ADDR) + longint'(NUM_BUFFERS) * longint'(BUFFER_SIZE);
    if (NUM_BUFFERS < 2 || NUM_BUFFERS > 4 || END_ADDR > (longint'(1) << ADDR_WIDTH)) begin : g_bad_params
        $fatal(1, "sdram_frame_buffer_mgr: NUM_BUFFERS must be 2..4 and all buffers must fit the address space");
    end
    function automatic logic [ADDR_WIDTH-1:0] buf_addr(input logic [IW-1:0] idx);
        return ADDR_WIDTH'(longint'(BASE_ADDR) + longint'(idx) * longint'(BUFFER_SIZE));
    endfunction
    // Buffer states are held as "who owns which index": at most one writer, one ready and one
    // reader slot, every other buffer is free.
    logic                      wr_held, rdy_held, rd_held;
    logic [IW-1:0]             wr_idx, rdy_idx, rd_idx;
    logic                      wr_ack, rd_ack, rd_rep;
    logic [DROP_CNT_WIDTH-1:0] drop;
    logic                      n_wr_held, n_rdy_held, n_rd_held;
    logic [IW-1:0]             n_wr_idx, n_rdy_idx, n_rd_idx;
    logic                      n_wr_ack, n_rd_ack, n_rd_rep;
    logic [DROP_CNT_WIDTH-1:0] n_drop;
    logic                      drop_inc, found;
    logic [IW-1:0]             free_idx;
    always_comb begin
        n_wr_held  = wr_held;
        n_wr_idx   = wr_idx;
        n_rdy_held = rdy_held;
        n_rdy_idx  = rdy_idx;
        n_rd_held  = rd_held;
        n_rd_idx   = rd_idx;
        n_rd_rep   = rd_rep;
        n_wr_ack   = 1'b0;
        n_rd_ack   = 1'b0;
        drop_inc   = 1'b0;
        found      = 1'b0;
        free_idx   = '0;
        if (bus.wr_frame_done && wr_held) begin
            drop_inc   = rdy_held;
            n_rdy_held = 1'b1;
            n_rdy_idx  = wr_idx;
            n_wr_held  = 1'b0;
        end
        // The reader's old buffer is simply released by overwriting its ownership slot.
        if (bus.rd_frame_req) begin
            n_rd_ack = 1'b1;
            n_rd_rep = !n_rdy_held;
            if (n_rdy_held) begin
                n_rd_held  = 1'b1;
                n_rd_idx   = n_rdy_idx;
                n_rdy_held = 1'b0;
            end
        end
        // Downward scan so the lowest free index wins.
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (!(n_wr_held && n_wr_idx == IW'(i)) && !(n_rdy_held && n_rdy_idx == IW'(i)) &&
                !(n_rd_held && n_rd_idx == IW'(i))) begin
                found    = 1'b1;
                free_idx = IW'(i);
            end
        end
        // With no free buffer the ready one is the only candidate (writer holds nothing here).
        if (bus.wr_frame_req && !n_wr_held) begin
            n_wr_ack  = 1'b1;
            n_wr_held = 1'b1;
            n_wr_idx  = found ? free_idx : n_rdy_idx;
            if (!found) begin
                drop_inc   = 1'b1;
                n_rdy_held = 1'b0;
            end
        end
        n_drop = (drop_inc && drop != '1) ? drop + DROP_CNT_WIDTH'(1) : drop;
    end
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            wr_held  <= 1'b0;
            rdy_held <= 1'b0;
            rd_held  <= 1'b0;
            wr_idx   <= '0;
            rdy_idx  <= '0;
            rd_idx   <= '0;
            wr_ack   <= 1'b0;
            rd_ack   <= 1'b0;
            rd_rep   <= 1'b0;
            drop     <= '0;
        end else begin
            wr_held  <= n_wr_held;
            rdy_held <= n_rdy_held;
            rd_held  <= n_rd_held;
            wr_idx   <= n_wr_idx;
            rdy_idx  <= n_rdy_idx;
            rd_idx   <= n_rd_idx;
            wr_ack   <= n_wr_ack;
            rd_ack   <= n_rd_ack;
            rd_rep   <= n_rd_rep;
            drop     <= n_drop;
        end
    end
    assign bus.wr_frame_ack = wr_ack;
    assign bus.wr_base_addr = buf_addr(wr_idx);
    assign bus.wr_buf_idx   = wr_idx;
    assign bus.rd_frame_ack = rd_ack;
    assign bus.rd_base_addr = buf_addr(rd_idx);
    assign bus.rd_buf_idx   = rd_idx;
    assign bus.rd_repeat    = rd_rep;
    assign bus.rd_has_frame = rd_held;
    assign bus.drop_count   = drop;
endmodule

// File: tb/tb_sdram_frame_buffer_mgr.sv
// tb_sdram_frame_buffer_mgr: bench for a default 3-buffer manager and a small 2-buffer manager
module tb_sdram_frame_buffer_mgr;
    localparam int SA = 307200;
    localparam int BB = 16;
    localparam int SB = 1000;
    typedef enum int {FREE, WRITING, READY, READING} bst_t;
    typedef struct {
        bit rst, done, rq, wq;
        bit wack, rack;
        int widx, ridx;
        bit rep, has;
        int drop;
    } vec_t;
    logic axi_clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    bst_t st[2][4];
    int e_widx[2], e_ridx[2], e_drop[2];
    bit e_wack[2], e_rack[2], e_rep[2];
    vec_t tv[$];
    always #5 axi_clk = ~axi_clk;
    sdram_frame_buffer_mgr_if #(.ADDR_WIDTH(24), .NUM_BUFFERS(3), .DROP_CNT_WIDTH(16)) ifa ();
    sdram_frame_buffer_mgr_if #(.ADDR_WIDTH(16), .NUM_BUFFERS(2), .DROP_CNT_WIDTH(3)) ifb ();
    sdram_frame_buffer_mgr dut_a (.axi_clk(axi_clk), .axi_rst(rst_a), .bus(ifa));
    sdram_frame_buffer_mgr #(
        .ADDR_WIDTH(16), .NUM_BUFFERS(2), .BUFFER_SIZE(SB), .BASE_ADDR(BB), .DROP_CNT_WIDTH(3)
    ) dut_b (.axi_clk(axi_clk), .axi_rst(rst_b), .bus(ifb));
    function automatic int nbuf(input int k);
        return k ? 2 : 3;
    endfunction
    function automatic int base(input int k);
        return k ? BB : 0;
    endfunction
    function automatic int bsize(input int k);
        return k ? SB : SA;
    endfunction
    function automatic int dmax(input int k);
        return k ? 7 : 65535;
    endfunction
    function automatic int find(input int k, input bst_t s);
        for (int i = 0; i < nbuf(k); i++) if (st[k][i] == s) return i;
        return -1;
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask
    task automatic set_in(input int k, input bit r, input bit d, input bit q, input bit w);
        if (k == 0) begin
            rst_a = r; ifa.wr_frame_done = d; ifa.rd_frame_req = q; ifa.wr_frame_req = w;
        end else begin
            rst_b = r; ifb.wr_frame_done = d; ifb.rd_frame_req = q; ifb.wr_frame_req = w;
        end
    endtask
    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask
    task automatic drop_bump(input int k);
        if (e_drop[k] < dmax(k)) e_drop[k]++;
    endtask
    // Reference: explicit per-buffer state table, events applied in done / read / write order.
    task automatic model_step(input int k, input bit r, input bit d, input bit q, input bit w);
        int wi, ri, hi, fi;
        e_wack[k] = 0;
        e_rack[k] = 0;
        if (r) begin
            for (int i = 0; i < 4; i++) st[k][i] = FREE;
            e_widx[k] = 0; e_ridx[k] = 0; e_drop[k] = 0; e_rep[k] = 0;
            return;
        end
        wi = find(k, WRITING);
        if (d && wi >= 0) begin
            ri = find(k, READY);
            if (ri >= 0) begin
                st[k][ri] = FREE;
                drop_bump(k);
            end
            st[k][wi] = READY;
        end
        if (q) begin
            e_rack[k] = 1;
            ri = find(k, READY);
            e_rep[k] = (ri < 0);
            if (ri >= 0) begin
                hi = find(k, READING);
                if (hi >= 0) st[k][hi] = FREE;
                st[k][ri] = READING;
                e_ridx[k] = ri;
            end
        end
        if (w && find(k, WRITING) < 0) begin
            fi = find(k, FREE);
            if (fi < 0) begin
                fi = find(k, READY);
                drop_bump(k);
            end
            st[k][fi] = WRITING;
            e_wack[k] = 1;
            e_widx[k] = fi;
        end
    endtask
    task automatic check_dut(input int k);
        string p = k ? "b." : "a.";
        chk({p, "wr_ack"},  k ? ifb.wr_frame_ack : ifa.wr_frame_ack, e_wack[k]);
        chk({p, "rd_ack"},  k ? ifb.rd_frame_ack : ifa.rd_frame_ack, e_rack[k]);
        chk({p, "wr_idx"},  k ? ifb.wr_buf_idx : ifa.wr_buf_idx, e_widx[k]);
        chk({p, "wr_addr"}, k ? ifb.wr_base_addr : ifa.wr_base_addr, base(k) + e_widx[k] * bsize(k));
        chk({p, "rd_idx"},  k ? ifb.rd_buf_idx : ifa.rd_buf_idx, e_ridx[k]);
        chk({p, "rd_addr"}, k ? ifb.rd_base_addr : ifa.rd_base_addr, base(k) + e_ridx[k] * bsize(k));
        chk({p, "repeat"},  k ? ifb.rd_repeat : ifa.rd_repeat, e_rep[k]);
        chk({p, "has"},     k ? ifb.rd_has_frame : ifa.rd_has_frame, find(k, READING) >= 0);
        chk({p, "drop"},    k ? ifb.drop_count : ifa.drop_count, e_drop[k]);
    endtask
    task automatic step_b(input bit d, input bit q, input bit w);
        set_in(1, 0, d, q, w);
        tick();
    endtask
    initial begin
        bit r, d, q, w;
        // rst done rq wq | wack rack widx ridx rep has drop
        tv.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0});
        tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
        tv.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0});
        tv.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0});
        tv.push_back('{0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0});
        tv.push_back('{0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0});
        tv.push_back('{0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0});
        tv.push_back('{0, 0, 0, 1, 1, 0, 2, 0, 0, 1, 0});
        tv.push_back('{0, 1, 0, 0, 0, 0, 2, 0, 0, 1, 1});
        tv.push_back('{0, 0, 1, 0, 0, 1, 2, 2, 0, 1, 1});
        tv.push_back('{0, 0, 0, 1, 1, 0, 0, 2, 0, 1, 1});
        tv.push_back('{0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1});
        tv.push_back('{0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1});
        tv.push_back('{0, 1, 0, 1, 1, 0, 2, 0, 0, 1, 1});
        tv.push_back('{0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 1});
        tv.push_back('{0, 0, 1, 0, 0, 1, 2, 1, 0, 1, 1});
        tv.push_back('{0, 0, 1, 0, 0, 1, 2, 1, 1, 1, 1});
        tv.push_back('{0, 1, 0, 0, 0, 0, 2, 1, 1, 1, 1});
        tv.push_back('{0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1});
        tv.push_back('{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 2});
        tv.push_back('{0, 0, 0, 1, 1, 0, 2, 1, 1, 1, 2});
        tv.push_back('{0, 1, 0, 0, 0, 0, 2, 1, 1, 1, 3});
        tv.push_back('{0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 3});
        tv.push_back('{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 4});
        tv.push_back('{0, 0, 0, 1, 1, 0, 2, 1, 1, 1, 4});
        tv.push_back('{0, 1, 0, 0, 0, 0, 2, 1, 1, 1, 5});
        tv.push_back('{0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 5});
        tv.push_back('{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0});
        set_in(1, 1, 0, 0, 0);
        for (int i = 0; i < tv.size(); i++) begin
            set_in(0, tv[i].rst, tv[i].done, tv[i].rq, tv[i].wq);
            tick();
            chk($sformatf("row%0d wr_ack", i),  ifa.wr_frame_ack, tv[i].wack);
            chk($sformatf("row%0d rd_ack", i),  ifa.rd_frame_ack, tv[i].rack);
            chk($sformatf("row%0d wr_idx", i),  ifa.wr_buf_idx, tv[i].widx);
            chk($sformatf("row%0d wr_addr", i), ifa.wr_base_addr, tv[i].widx * SA);
            chk($sformatf("row%0d rd_idx", i),  ifa.rd_buf_idx, tv[i].ridx);
            chk($sformatf("row%0d rd_addr", i), ifa.rd_base_addr, tv[i].ridx * SA);
            chk($sformatf("row%0d repeat", i),  ifa.rd_repeat, tv[i].rep);
            chk($sformatf("row%0d has", i),     ifa.rd_has_frame, tv[i].has);
            chk($sformatf("row%0d drop", i),    ifa.drop_count, tv[i].drop);
        end
        // Two-buffer corner: reader on buf1, buf0 ready, then reclaim vs. same-cycle swap.
        set_in(0, 1, 0, 0, 0);
        set_in(1, 1, 0, 0, 0);
        tick();
        step_b(0, 0, 1);
        step_b(1, 0, 0);
        step_b(0, 1, 0);
        step_b(0, 0, 1);
        step_b(1, 0, 0);
        step_b(0, 1, 0);
        step_b(0, 0, 1);
        step_b(1, 0, 0);
        chk("b.setup rd_idx", ifb.rd_buf_idx, 1);
        chk("b.setup rd_addr", ifb.rd_base_addr, BB + SB);
        step_b(0, 0, 1);
        chk("b.reclaim wr_ack", ifb.wr_frame_ack, 1);
        chk("b.reclaim wr_idx", ifb.wr_buf_idx, 0);
        chk("b.reclaim wr_addr", ifb.wr_base_addr, BB);
        chk("b.reclaim drop", ifb.drop_count, 1);
        step_b(1, 0, 0);
        chk("b.done drop", ifb.drop_count, 1);
        step_b(0, 1, 1);
        chk("b.swap rd_ack", ifb.rd_frame_ack, 1);
        chk("b.swap repeat", ifb.rd_repeat, 0);
        chk("b.swap rd_idx", ifb.rd_buf_idx, 0);
        chk("b.swap rd_addr", ifb.rd_base_addr, BB);
        chk("b.swap wr_ack", ifb.wr_frame_ack, 1);
        chk("b.swap wr_idx", ifb.wr_buf_idx, 1);
        chk("b.swap wr_addr", ifb.wr_base_addr, BB + SB);
        chk("b.swap drop", ifb.drop_count, 1);
        // Randomized traffic on both managers against the state-table reference.
        for (int k = 0; k < 2; k++) begin
            set_in(k, 1, 0, 0, 0);
            model_step(k, 1, 0, 0, 0);
        end
        tick();
        check_dut(0);
        check_dut(1);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                r = ($urandom_range(0, 149) == 0);
                d = ($urandom_range(0, 2) == 0);
                q = ($urandom_range(0, 2) == 0);
                w = ($urandom_range(0, 1) == 0);
                set_in(k, r, d, q, w);
                model_step(k, r, d, q, w);
            end
            tick();
            check_dut(0);
            check_dut(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
